fetch_ctrl: RTL and testbench

Instruction-fetch controller for the 8-bit core. Owns the program counter that addresses the combinational instruction memory (`ins_mem`). Latches each fetched byte into a single-entry instruction register. Hands it to decode through a valid/ready handshake. Handles branch redirects, halt/resume, PC wrap-around and a retired-fetch counter.

---
 rtl/fetch_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, a single-entry instruction register
// with valid/ready handoff to decode, branch redirect, halt/resume and a fetch counter.
module fetch_ctrl #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  pc_addr,
    input  logic [7:0]  inst_in,
    output logic [7:0]  ir_out,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state_r;
    logic   slot_free_s;

    // The IR may be overwritten or cleared when empty or being consumed this cycle.
    always_comb begin
        slot_free_s = (!ir_valid) || ir_ready;
    end

    // Fetch state machine: per-cycle priority is redirect, halt, resume, load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            pc_addr     <= RESET_PC;
            ir_out      <= 8'h00;
            ir_pc       <= 8'h00;
            ir_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'h0000;
        end else if (redirect) begin
            // Flush; a coincident transfer has already been taken by decode.
            state_r  <= ST_RUN;
            halted   <= 1'b0;
            pc_addr  <= redirect_addr;
            ir_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_req) begin
                        state_r <= ST_HALTED;
                        halted  <= 1'b1;
                        if (slot_free_s) begin
                            ir_valid <= 1'b0;
                        end else begin
                            ir_valid <= ir_valid;
                        end
                    end else if (slot_free_s) begin
                        ir_out   <= inst_in;
                        ir_pc    <= pc_addr;
                        ir_valid <= 1'b1;
                        pc_addr  <= pc_addr + 8'h01;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'h0001;
                        end else begin
                            fetch_count <= fetch_count;
                        end
                        // The halt opcode itself is still delivered and the PC steps past it.
                        if (inst_in == HALT_OPCODE) begin
                            state_r <= ST_HALTED;
                            halted  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            halted  <= 1'b0;
                        end
                    end else begin
                        ir_valid <= ir_valid;
                    end
                end
                ST_HALTED: begin
                    if (resume && !halt_req) begin
                        state_r <= ST_RUN;
                        halted  <= 1'b0;
                    end else begin
                        state_r <= ST_HALTED;
                        halted  <= 1'b1;
                    end
                    if (slot_free_s) begin
                        ir_valid <= 1'b0;
                    end else begin
                        ir_valid <= ir_valid;
                    end
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted   <= 1'b0;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a combinational memory model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc_addr;
    logic [7:0]  inst_in;
    logic [7:0]  ir_out;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0]  mem [0:255];
    int          n_checks;
    int          n_fail;

    fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_addr      (pc_addr),
        .inst_in      (inst_in),
        .ir_out       (ir_out),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .halt_req     (halt_req),
        .resume       (resume),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    assign inst_in = mem[pc_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible IR/PC/counter state in one call.
    task automatic chk_ir(input string tag, input logic v, input logic [7:0] ipc,
                          input logic [7:0] iout, input logic [7:0] pc,
                          input logic [15:0] fc, input logic h);
        chk({tag, ".ir_valid"}, {15'd0, ir_valid}, {15'd0, v});
        if (v) begin
            chk({tag, ".ir_pc"}, {8'd0, ir_pc}, {8'd0, ipc});
            chk({tag, ".ir_out"}, {8'd0, ir_out}, {8'd0, iout});
        end
        chk({tag, ".pc_addr"}, {8'd0, pc_addr}, {8'd0, pc});
        chk({tag, ".fetch_count"}, fetch_count, fc);
        chk({tag, ".halted"}, {15'd0, halted}, {15'd0, h});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
        mem[8'h10] = 8'hFF;

        rst_n = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_addr = 8'h00;
        halt_req = 1'b0; resume = 1'b0;
        step(); step();
        chk_ir("reset", 1'b0, 8'h00, 8'h00, 8'h00, 16'd0, 1'b0);
        chk("reset.ir_out", {8'd0, ir_out}, 16'h0000);
        chk("reset.ir_pc", {8'd0, ir_pc}, 16'h0000);

        // Streaming
        rst_n = 1'b1;
        step(); chk_ir("s0", 1'b1, 8'h00, 8'h5A, 8'h01, 16'd1, 1'b0);
        step(); chk_ir("s1", 1'b1, 8'h01, 8'h5B, 8'h02, 16'd2, 1'b0);
        step(); chk_ir("s2", 1'b1, 8'h02, 8'h58, 8'h03, 16'd3, 1'b0);
        step(); chk_ir("s3", 1'b1, 8'h03, 8'h59, 8'h04, 16'd4, 1'b0);

        // Backpressure
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_ir("bp", 1'b1, 8'h03, 8'h59, 8'h04, 16'd4, 1'b0);
        end
        ir_ready = 1'b1;
        step(); chk_ir("bp_rel", 1'b1, 8'h04, 8'h5E, 8'h05, 16'd5, 1'b0);

        // Redirect with a stalled IR
        ir_ready = 1'b0; redirect = 1'b1; redirect_addr = 8'h40;
        step(); chk_ir("redir", 1'b0, 8'h00, 8'h00, 8'h40, 16'd5, 1'b0);
        redirect = 1'b0; ir_ready = 1'b1;
        step(); chk_ir("redir_tgt", 1'b1, 8'h40, 8'h1A, 8'h41, 16'd6, 1'b0);

        // Wrap-around
        redirect = 1'b1; redirect_addr = 8'hFE;
        step(); chk_ir("wrap_redir", 1'b0, 8'h00, 8'h00, 8'hFE, 16'd6, 1'b0);
        redirect = 1'b0;
        step(); chk_ir("wrap_fe", 1'b1, 8'hFE, 8'hA4, 8'hFF, 16'd7, 1'b0);
        step(); chk_ir("wrap_ff", 1'b1, 8'hFF, 8'hA5, 8'h00, 16'd8, 1'b0);
        step(); chk_ir("wrap_00", 1'b1, 8'h00, 8'h5A, 8'h01, 16'd9, 1'b0);
        step(); chk_ir("wrap_01", 1'b1, 8'h01, 8'h5B, 8'h02, 16'd10, 1'b0);

        // Halt opcode at 0x10
        redirect = 1'b1; redirect_addr = 8'h10;
        step(); chk_ir("h_redir", 1'b0, 8'h00, 8'h00, 8'h10, 16'd10, 1'b0);
        redirect = 1'b0;
        step(); chk_ir("h_load", 1'b1, 8'h10, 8'hFF, 8'h11, 16'd11, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(); chk_ir("h_idle", 1'b0, 8'h00, 8'h00, 8'h11, 16'd11, 1'b1);
        end
        resume = 1'b1;
        step(); chk_ir("h_resume", 1'b0, 8'h00, 8'h00, 8'h11, 16'd11, 1'b0);
        resume = 1'b0;
        step(); chk_ir("h_next", 1'b1, 8'h11, 8'h4B, 8'h12, 16'd12, 1'b0);

        // Simultaneous halt_req + redirect in RUN: redirect wins
        halt_req = 1'b1; redirect = 1'b1; redirect_addr = 8'h80;
        step(); chk_ir("hr_redir", 1'b0, 8'h00, 8'h00, 8'h80, 16'd12, 1'b0);
        halt_req = 1'b0; redirect = 1'b0;
        step(); chk_ir("hr_load", 1'b1, 8'h80, 8'hDA, 8'h81, 16'd13, 1'b0);

        // halt_req, then halt_req + resume in HALTED stays halted
        halt_req = 1'b1;
        step(); chk_ir("hq", 1'b0, 8'h00, 8'h00, 8'h81, 16'd13, 1'b1);
        resume = 1'b1;
        step(); chk_ir("hq_res", 1'b0, 8'h00, 8'h00, 8'h81, 16'd13, 1'b1);
        halt_req = 1'b0; resume = 1'b0;
        step(); chk_ir("hq_idle", 1'b0, 8'h00, 8'h00, 8'h81, 16'd13, 1'b1);
        resume = 1'b1;
        step(); chk_ir("hq_resume", 1'b0, 8'h00, 8'h00, 8'h81, 16'd13, 1'b0);
        resume = 1'b0;
        step(); chk_ir("hq_next", 1'b1, 8'h81, 8'hDB, 8'h82, 16'd14, 1'b0);

        // Reset mid-stream
        step(); chk_ir("pre_rst", 1'b1, 8'h82, 8'hD8, 8'h83, 16'd15, 1'b0);
        rst_n = 1'b0;
        step(); chk_ir("mid_rst", 1'b0, 8'h00, 8'h00, 8'h00, 16'd0, 1'b0);
        chk("mid_rst.ir_out", {8'd0, ir_out}, 16'h0000);
        chk("mid_rst.ir_pc", {8'd0, ir_pc}, 16'h0000);
        rst_n = 1'b1;
        step(); chk_ir("restart", 1'b1, 8'h00, 8'h5A, 8'h01, 16'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
